// File: rtl/sram_controller.sv
// Bridges one 32-bit load/store from the memory stage onto a 16-bit asynchronous SRAM
// as two back-to-back half-word accesses, stalling the pipeline through `ready`.
module sram_controller #(
  parameter int WORD_WIDTH      = 32,
  parameter int SRAM_DATA_WIDTH = 16,
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int BASE_ADDR       = 1024,
  parameter int ACCESS_CYCLES   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [WORD_WIDTH-1:0]      address,
  input  logic [WORD_WIDTH-1:0]      write_data,
  output logic [WORD_WIDTH-1:0]      read_data,
  output logic                       ready,
  inout  wire  [SRAM_DATA_WIDTH-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic                       SRAM_WE_N,
  output logic                       SRAM_CE_N,
  output logic                       SRAM_OE_N,
  output logic                       SRAM_UB_N,
  output logic                       SRAM_LB_N,
  output logic [2:0]                 dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [WORD_WIDTH-1:0] BASE     = WORD_WIDTH'(BASE_ADDR);

  state_t                      state, state_nx;
  logic [CNT_W-1:0]            cnt, cnt_nx;
  logic [WORD_WIDTH-1:0]       addr_q, wdata_q;
  logic [WORD_WIDTH-1:0]       off;
  logic [SRAM_ADDR_WIDTH-2:0]  widx;
  logic                        last;
  logic                        dq_oe;
  logic [SRAM_DATA_WIDTH-1:0]  dq_out;
  logic                        unused_off_bits;

  assign off  = addr_q - BASE;
  assign widx = off[SRAM_ADDR_WIDTH:2];
  assign last = (cnt == CNT_LAST);
  assign unused_off_bits = ^{off[1:0], off[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1]};

  // Handshake: a request (rd_en/wr_en) is taken on the edge where it is seen in IDLE;
  // `ready` is high only when nothing is pending (idle with no request) or in DONE.
  assign ready = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if ((state == IDLE) && (rd_en || wr_en)) begin
        addr_q  <= address;
        wdata_q <= write_data;
      end
      if ((state == RD_LO) && last)
        read_data[SRAM_DATA_WIDTH-1:0] <= SRAM_DQ;
      if ((state == RD_HI) && last)
        read_data[WORD_WIDTH-1 -: SRAM_DATA_WIDTH] <= SRAM_DQ;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    case (state)
      IDLE: begin
        if (wr_en)      state_nx = WR_LO;
        else if (rd_en) state_nx = RD_LO;
      end
      RD_LO:   if (last) state_nx = RD_HI;
      RD_HI:   if (last) state_nx = DONE;
      WR_LO:   if (last) state_nx = WR_HI;
      WR_HI:   if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // The phase counter only runs while a phase state is held.
    if ((state_nx == state) && (state != IDLE) && (state != DONE))
      cnt_nx = cnt + 1'b1;
  end

  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    case (state)
      RD_LO: SRAM_ADDR = {widx, 1'b0};
      RD_HI: SRAM_ADDR = {widx, 1'b1};
      WR_LO: begin
        SRAM_ADDR = {widx, 1'b0};
        SRAM_WE_N = last;
        dq_oe     = 1'b1;
        dq_out    = wdata_q[SRAM_DATA_WIDTH-1:0];
      end
      WR_HI: begin
        // WE rises one cycle before the phase ends so address/data outlive it.
        SRAM_ADDR = {widx, 1'b1};
        SRAM_WE_N = last;
        dq_oe     = 1'b1;
        dq_out    = wdata_q[WORD_WIDTH-1 -: SRAM_DATA_WIDTH];
      end
      default: ;
    endcase
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign dbg_state = state;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized self-checking bench for sram_controller: an SRAM device model on the pins
// and a word-level reference model of memory contents, latency and strobe timing.
module tb_sram_controller;

  localparam int A    = 2;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;
  logic [2:0]  dbg_state;

  sram_controller #(
    .WORD_WIDTH(32), .SRAM_DATA_WIDTH(16), .SRAM_ADDR_WIDTH(18),
    .BASE_ADDR(BASE), .ACCESS_CYCLES(A)
  ) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
    .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n),
    .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // SRAM device: unwritten locations return a fixed pattern; writes land on WE rising edge
  logic [15:0] sram_mem [int];
  logic        tb_reading = 1'b0;
  logic [15:0] dq_drv = '0;

  function automatic logic [15:0] init_val(int loc);
    return 16'((loc * 9) ^ 32'h5A5A);
  endfunction

  function automatic logic [15:0] dev_read(int loc);
    if (sram_mem.exists(loc)) return sram_mem[loc];
    return init_val(loc);
  endfunction

  always @(sram_addr or tb_reading) dq_drv = dev_read(int'(sram_addr));
  assign sram_dq = tb_reading ? dq_drv : 16'bz;

  always @(posedge sram_we_n)
    if (!$isunknown(sram_addr) && !$isunknown(sram_dq))
      sram_mem[int'(sram_addr)] = sram_dq;

  // reference model (word granularity)
  logic [31:0] ref_words [int];
  logic [31:0] ref_read = '0;
  logic [31:0] exp_q[$];

  function automatic int widx_of(logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return int'(off >> 2) & ((1 << 17) - 1);
  endfunction

  function automatic logic [31:0] ref_load(int w);
    if (ref_words.exists(w)) return ref_words[w];
    return {init_val(2 * w + 1), init_val(2 * w)};
  endfunction

  function automatic logic [31:0] exp_we_mask(bit wr);
    logic [31:0] m;
    m = '0;
    if (wr)
      for (int c = 1; c <= 2 * A; c++)
        if (((c - 1) % A) < A - 1) m[c] = 1'b1;
    return m;
  endfunction

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: issue one request from IDLE (called just after a rising edge)
  task automatic run_req(input bit wr, input bit rd, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
    int          w;
    int          ready_cyc;
    logic [31:0] we_mask;
    logic [17:0] addr_lo_seen, addr_hi_seen;
    logic [31:0] exp;
    w = widx_of(a);
    if (!wr) exp_q.push_back(ref_load(w));
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    tb_reading = !wr;
    we_mask = '0; ready_cyc = -1;
    addr_lo_seen = 'x; addr_hi_seen = 'x;
    for (int c = 0; c < 4 * A + 4; c++) begin
      @(negedge clk);
      if (sram_we_n === 1'b0) we_mask[c] = 1'b1;
      if (c == 1)     addr_lo_seen = sram_addr;
      if (c == A + 1) addr_hi_seen = sram_addr;
      if (ready === 1'b1) begin
        ready_cyc = c;
        break;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
      end
    end
    check({tag, "_ready_cyc"}, 32'(ready_cyc), 32'(2 * A + 1));
    check({tag, "_we_mask"}, we_mask, exp_we_mask(wr));
    check({tag, "_addr_lo"}, 32'(addr_lo_seen), 32'(2 * w));
    check({tag, "_addr_hi"}, 32'(addr_hi_seen), 32'(2 * w + 1));
    check({tag, "_done_addr"}, 32'(sram_addr), 32'd0);
    if (wr) begin
      check({tag, "_rd_hold"}, read_data, ref_read);
      ref_words[w] = d;
      check({tag, "_mem"}, {dev_read(2 * w + 1), dev_read(2 * w)}, d);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_load"}, read_data, exp);
      ref_read = exp;
    end
    @(posedge clk); #1;
    tb_reading = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, rmask, exp_rmask, got_rd;
    int          w, op;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_read_data", read_data, 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_dq_z", 32'(sram_dq === 16'hzzzz), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // directed accesses
    run_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "st_1024");
    check("st_1024_loc0", 32'(dev_read(0)), 32'h0000BEEF);
    check("st_1024_loc1", 32'(dev_read(1)), 32'h0000DEAD);
    run_req(1'b0, 1'b1, 32'd1024, 32'h0, "ld_1024");
    run_req(1'b1, 1'b0, 32'd1028, $urandom, "st_1028");
    run_req(1'b0, 1'b1, 32'd1028, 32'h0, "ld_1028");
    run_req(1'b1, 1'b1, 32'd1032, 32'h12345678, "both_1032");
    check("both_loc4", 32'(dev_read(4)), 32'h00005678);
    check("both_loc5", 32'(dev_read(5)), 32'h00001234);

    // reset in cycle 2 of a store
    wr_en = 1'b1; address = 32'd1040; write_data = $urandom;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_we_n", 32'(sram_we_n), 32'd1);
    check("midrst_dq_z", 32'(sram_dq === 16'hzzzz), 32'd1);
    check("midrst_read_data", read_data, 32'd0);
    @(negedge clk);
    check("midrst_ready_hold", 32'(ready), 32'd1);
    rst = 1'b1;
    sram_mem.delete();
    ref_words.delete();
    ref_read = '0;
    @(posedge clk); #1;
    run_req(1'b0, 1'b1, 32'd1024, 32'h0, "ld_after_rst");

    // back-to-back store then load with requests held
    a = 32'(BASE) + 32'(4 * $urandom_range(0, 15));
    d = $urandom;
    w = widx_of(a);
    rd_en = 1'b0; wr_en = 1'b1; address = a; write_data = d;
    rmask = '0; got_rd = '0;
    for (int c = 0; c < 4 * A + 4; c++) begin
      @(negedge clk);
      if (ready === 1'b1) rmask[c] = 1'b1;
      if (c == 4 * A + 3) got_rd = read_data;
      @(posedge clk); #1;
      if (c == 2 * A + 1) begin wr_en = 1'b0; rd_en = 1'b1; tb_reading = 1'b1; end
      if (c == 4 * A + 3) begin rd_en = 1'b0; tb_reading = 1'b0; end
    end
    exp_rmask = (32'd1 << (2 * A + 1)) | (32'd1 << (4 * A + 3));
    check("b2b_ready_mask", rmask, exp_rmask);
    check("b2b_load", got_rd, d);
    ref_words[w] = d;
    ref_read = d;

    // randomized traffic with idle gaps
    repeat (40) begin
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0)
        a = 32'(BASE) - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
      else
        a = 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      run_req(op != 0, op != 1, a, $urandom, "rnd");
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("idle_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
